// File: rtl/conv_sram_read_arbiter.sv
// conv_sram_read_arbiter: round-robin/lockable arbiter sharing one SRAM read port between two conv engines
// Ports: clk, reset_b (async active-low); req0/1, lock0/1, addr0/1 requests; gnt0/1 combinational grants;
//   rvalid0/1, rdata0/1 registered tagged read returns; arb_sram_read_address registered SRAM address;
//   sram_arb_read_data SRAM data. Define ARB_PERF_CNT_EN to add gnt_cnt0/1 and force_rel_cnt counters.
module conv_sram_read_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1,
  parameter int MAX_LOCK = 64
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] arb_sram_read_address,
  input  logic [DATA_W-1:0] sram_arb_read_data
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       gnt_cnt0,
  output logic [31:0]       gnt_cnt1,
  output logic [15:0]       force_rel_cnt
`endif
);
  localparam int CW = $clog2(MAX_LOCK) + 1;
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  state_t state;
  logic rr_ptr;
  logic [CW-1:0] lock_cnt;
  logic [RD_LAT-1:0] tag_v, tag_id;
  logic locked, owner, own_req, own_lock, other_req, forced, win, win_id, tag_out0, tag_out1;
  always_comb begin
    locked = state != IDLE;
    owner = state == LOCK1;
    own_req = owner ? req1 : req0;
    own_lock = owner ? lock1 : lock0;
    other_req = owner ? req0 : req1;
    forced = locked && other_req && lock_cnt == CW'(MAX_LOCK - 1);
    win_id = locked ? owner : (req0 && req1) ? rr_ptr : req1;
    win = reset_b && (locked ? own_req && !forced : req0 || req1);
    gnt0 = win && !win_id;
    gnt1 = win && win_id;
    tag_out0 = tag_v[RD_LAT-1] && !tag_id[RD_LAT-1];
    tag_out1 = tag_v[RD_LAT-1] && tag_id[RD_LAT-1];
  end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      state <= IDLE;
      rr_ptr <= 1'b0;
      lock_cnt <= '0;
      arb_sram_read_address <= '0;
      tag_v <= '0;
      tag_id <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (win) arb_sram_read_address <= win_id ? addr1 : addr0;
      tag_v <= RD_LAT'({tag_v, win});
      tag_id <= RD_LAT'({tag_id, win_id});
      rvalid0 <= tag_out0;
      rvalid1 <= tag_out1;
      if (tag_out0) rdata0 <= sram_arb_read_data;
      if (tag_out1) rdata1 <= sram_arb_read_data;
      if (!locked) begin
        if (win) begin
          rr_ptr <= !win_id;
          if (win_id ? lock1 : lock0) state <= win_id ? LOCK1 : LOCK0;
        end
      end else if (forced || !own_lock) begin
        state <= IDLE;
        rr_ptr <= !owner;
        lock_cnt <= '0;
      end else if (other_req && lock_cnt != '1) lock_cnt <= lock_cnt + CW'(1);
    end
`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
      force_rel_cnt <= '0;
    end else begin
      if (gnt0) gnt_cnt0 <= gnt_cnt0 + 32'd1;
      if (gnt1) gnt_cnt1 <= gnt_cnt1 + 32'd1;
      if (forced && force_rel_cnt != '1) force_rel_cnt <= force_rel_cnt + 16'd1;
    end
`endif
endmodule
